// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, instruction field positions and fetch FSM encoding for the 16-bit RISC pipeline.
package risc_pkg;
    localparam int PC_W   = 16;
    localparam int REG_W  = 3;
    localparam int RS_LSB = 9;
    localparam int RT_LSB = 6;
    localparam int RD_LSB = 3;
    localparam logic [PC_W-1:0] NOP_ENC = 16'h0000;

    typedef enum logic [1:0] {BOOT, RUN, STALL, REDIRECT} state_e;

    function automatic logic [REG_W-1:0] reg_field(input logic [PC_W-1:0] instr, input int lsb);
        return instr[lsb +: REG_W];
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use comparator between the IF/ID source registers and a load in ID/EX.
module hazard_detect
    import risc_pkg::*;
(
    input  logic             i_valid,
    input  logic             i_mem_read,
    input  logic [REG_W-1:0] i_load_rt,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    output logic             o_hazard
);
    assign o_hazard = i_valid & i_mem_read & (i_load_rt == i_rs | i_load_rt == i_rt);
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC, fetch FSM and IF/ID register with load-use stall, branch squash and miss freeze.
// State updates on the falling edge so the rising-edge stages see stable IF/ID outputs.
module if_id_stage
    import risc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    input  logic [PC_W-1:0]  imem_data,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    output logic [PC_W-1:0]  imem_addr,
    output logic [PC_W-1:0]  instr_out,
    output logic [PC_W-1:0]  adder_pc_out,
    output logic             valid_out,
    output logic [REG_W-1:0] rs_out,
    output logic [REG_W-1:0] rt_out,
    output logic [REG_W-1:0] rd_out,
    output logic             id_bubble,
    output logic             flush_out,
    output logic [PC_W-1:0]  stall_count
);
    state_e          r_state, w_next_state;
    logic [PC_W-1:0] r_pc, r_instr, r_adder_pc, r_stall_count, w_pc_plus2;
    logic            r_valid, w_hazard, w_branch, w_stall;

    hazard_detect u_hazard (
        .i_valid   (r_valid),
        .i_mem_read(id_ex_mem_read),
        .i_load_rt (id_ex_rt),
        .i_rs      (rs_out),
        .i_rt      (rt_out),
        .o_hazard  (w_hazard)
    );

    assign w_pc_plus2   = r_pc + 16'd2;
    // Branches are only honoured once the pipe is running; hazards only from RUN
    assign w_branch     = branch_taken & (r_state == RUN | r_state == STALL);
    assign w_stall      = w_hazard & (r_state == RUN) & ~w_branch;
    assign imem_addr    = r_pc;
    assign instr_out    = r_instr;
    assign adder_pc_out = r_adder_pc;
    assign valid_out    = r_valid;
    assign stall_count  = r_stall_count;
    assign rs_out       = reg_field(r_instr, RS_LSB);
    assign rt_out       = reg_field(r_instr, RT_LSB);
    assign rd_out       = reg_field(r_instr, RD_LSB);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else if (hit) r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = w_branch ? REDIRECT : (w_stall ? STALL : RUN);
    end

    always_comb begin
        id_bubble = hit & w_stall;
        flush_out = hit & w_branch;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_adder_pc    <= '0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
        end else if (hit) begin
            if (w_branch) begin
                r_pc       <= branch_target & ~16'd1;
                r_instr    <= NOP_INSTR;
                r_adder_pc <= '0;
                r_valid    <= 1'b0;
            end else if (w_stall) begin
                r_stall_count <= (&r_stall_count) ? r_stall_count : r_stall_count + 16'd1;
            end else begin
                r_pc       <= w_pc_plus2;
                r_instr    <= imem_data;
                r_adder_pc <= w_pc_plus2;
                r_valid    <= 1'b1;
            end
        end
    end
endmodule
